mesm6_mem_arbiter: RTL and testbench

Single-port memory arbiter directly downstream of the MESM-6 core. It serves the core's instruction bus (`ibus_*`) and data bus (`dbus_*`) from one synchronous SRAM port of 32K × 48-bit words. It turns the core's level-held requests into one-at-a-time SRAM accesses, returns read data, and pulses `*_done` to release the core's busy stall.

---
 rtl/mesm6_pkg.sv | 35 +++
 rtl/mesm6_mem_arbiter.sv | 109 ++++++++++
 tb/tb_mesm6_mem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mesm6_pkg.sv
// Shared MESM-6 definitions: memory geometry and the memory arbiter's types.
// Imported by the core-side memory blocks.
package mesm6_pkg;

  localparam int MEM_ADDR_BITS = 15;
  localparam int MEM_WORD_BITS = 48;

  typedef logic [MEM_ADDR_BITS-1:0] mem_addr_t;
  typedef logic [MEM_WORD_BITS-1:0] mem_word_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_DONE
  } arb_state_t;

  typedef enum logic {
    OWNER_IBUS,
    OWNER_DBUS
  } arb_owner_t;

  // Everything about the winning request that must survive past the IDLE sample.
  typedef struct packed {
    arb_owner_t owner;
    logic       write;
    logic       zero;
  } arb_req_t;

  // Data-bus word 0 is hardwired to zero and never reaches the SRAM.
  function automatic logic is_zero_addr(input mem_addr_t addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/mesm6_mem_arbiter.sv
// Single-port SRAM arbiter for the MESM-6 instruction and data buses.
// dbus has priority; one access is outstanding at a time and every output is registered.
module mesm6_mem_arbiter
  import mesm6_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     ibus_fetch,
  input  logic [MEM_ADDR_BITS-1:0] ibus_addr,
  output logic [MEM_WORD_BITS-1:0] ibus_input,
  output logic                     ibus_done,

  input  logic                     dbus_read,
  input  logic                     dbus_write,
  input  logic [MEM_ADDR_BITS-1:0] dbus_addr,
  input  logic [MEM_WORD_BITS-1:0] dbus_output,
  output logic [MEM_WORD_BITS-1:0] dbus_input,
  output logic                     dbus_done,

  output logic                     mem_en,
  output logic                     mem_we,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [MEM_WORD_BITS-1:0] mem_wdata,
  input  logic [MEM_WORD_BITS-1:0] mem_rdata
);

  localparam int CNT_W = 2;

  arb_state_t       state;
  arb_req_t         req;
  logic [CNT_W-1:0] lat_cnt;

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments only, so every register
    // in this block sees pre-edge values regardless of statement order.
    if (reset) begin
      state      <= ARB_IDLE;
      req        <= '0;
      lat_cnt    <= '0;
      ibus_done  <= 1'b0;
      dbus_done  <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ibus_input <= '0;
      dbus_input <= '0;
    end else begin
      ibus_done <= 1'b0;
      dbus_done <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;

      case (state)
        ARB_IDLE: begin
          if (dbus_read || dbus_write) begin
            req       <= '{owner: OWNER_DBUS, write: dbus_write, zero: is_zero_addr(dbus_addr)};
            mem_en    <= !is_zero_addr(dbus_addr);
            mem_we    <= dbus_write && !is_zero_addr(dbus_addr);
            mem_addr  <= dbus_addr;
            mem_wdata <= dbus_write ? dbus_output : '0;
            state     <= ARB_ISSUE;
          end else if (ibus_fetch) begin
            req       <= '{owner: OWNER_IBUS, write: 1'b0, zero: 1'b0};
            mem_en    <= 1'b1;
            mem_addr  <= ibus_addr;
            mem_wdata <= '0;
            state     <= ARB_ISSUE;
          end
        end

        // The access strobe is visible during this state.
        ARB_ISSUE: begin
          if (req.write) begin
            dbus_done <= 1'b1;
            state     <= ARB_DONE;
          end else begin
            lat_cnt <= CNT_W'(RD_LATENCY - 1);
            state   <= ARB_WAIT;
          end
        end

        ARB_WAIT: begin
          if (lat_cnt == '0) begin
            if (req.owner == OWNER_DBUS) begin
              dbus_input <= req.zero ? '0 : mem_rdata;
              dbus_done  <= 1'b1;
            end else begin
              ibus_input <= mem_rdata;
              ibus_done  <= 1'b1;
            end
            state <= ARB_DONE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end

        // Mandatory gap: the core drops or renews its request off the done pulse.
        ARB_DONE: state <= ARB_IDLE;

        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesm6_mem_arbiter.sv
// Bench for mesm6_mem_arbiter: two instances (RD_LATENCY 1 and 4), each with a
// behavioural SRAM, checked against a transaction-level timing and memory model.
module tb_mesm6_mem_arbiter;

  typedef enum int {K_FETCH, K_READ, K_WRITE} kind_e;

  logic        clk;
  logic        reset       [2];
  logic        ibus_fetch  [2];
  logic [14:0] ibus_addr   [2];
  wire  [47:0] ibus_input  [2];
  wire         ibus_done   [2];
  logic        dbus_read   [2];
  logic        dbus_write  [2];
  logic [14:0] dbus_addr   [2];
  logic [47:0] dbus_output [2];
  wire  [47:0] dbus_input  [2];
  wire         dbus_done   [2];
  wire         mem_en      [2];
  wire         mem_we      [2];
  wire  [14:0] mem_addr    [2];
  wire  [47:0] mem_wdata   [2];
  wire  [47:0] mem_rdata   [2];

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // Reference model: what the core believes memory holds, plus expected held outputs.
  logic [47:0] ref_mem [int];
  logic [47:0] last_ibus [2];
  logic [47:0] last_dbus [2];

  int   viol      [2] = '{0, 0};
  logic prev_done [2] = '{1'b0, 1'b0};

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [47:0] init_word(input logic [14:0] a);
    if (a == 15'o100) return 48'h1234_5678_9ABC;
    return {a, ~a, 18'(a) ^ 18'h2A5A5};
  endfunction

  function automatic logic [47:0] model_word(input int d, input logic [14:0] a);
    int key;
    key = d * 32768 + int'(a);
    if (ref_mem.exists(key)) return ref_mem[key];
    return init_word(a);
  endfunction

  function automatic logic [14:0] rand15();
    return 15'($urandom_range(0, 32767));
  endfunction

  function automatic logic [47:0] rand48();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[47:0];
  endfunction

  function automatic logic [162:0] outs(input int d);
    return {ibus_done[d], dbus_done[d], mem_en[d], mem_we[d], mem_addr[d],
            mem_wdata[d], ibus_input[d], dbus_input[d]};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : 4;
    logic [47:0] sram       [32768];
    bit          sram_valid [32768];
    logic [47:0] rq [L];
    logic        rv [L] = '{default: 1'b0};

    // Behavioural mesm6_sram: data appears L cycles after the mem_en cycle, junk otherwise.
    always @(posedge clk) begin
      if (mem_en[g] && mem_we[g]) begin
        sram[mem_addr[g]]       <= mem_wdata[g];
        sram_valid[mem_addr[g]] <= 1'b1;
      end
      rv[0] <= mem_en[g] && !mem_we[g];
      rq[0] <= sram_valid[mem_addr[g]] ? sram[mem_addr[g]] : init_word(mem_addr[g]);
      for (int i = 1; i < L; i++) begin
        rq[i] <= rq[i-1];
        rv[i] <= rv[i-1];
      end
    end
    assign mem_rdata[g] = rv[L-1] ? rq[L-1] : 48'h0BAD_0BAD_0BAD;

    mesm6_mem_arbiter #(.RD_LATENCY(L)) u_dut (
      .clk         (clk),
      .reset       (reset[g]),
      .ibus_fetch  (ibus_fetch[g]),
      .ibus_addr   (ibus_addr[g]),
      .ibus_input  (ibus_input[g]),
      .ibus_done   (ibus_done[g]),
      .dbus_read   (dbus_read[g]),
      .dbus_write  (dbus_write[g]),
      .dbus_addr   (dbus_addr[g]),
      .dbus_output (dbus_output[g]),
      .dbus_input  (dbus_input[g]),
      .dbus_done   (dbus_done[g]),
      .mem_en      (mem_en[g]),
      .mem_we      (mem_we[g]),
      .mem_addr    (mem_addr[g]),
      .mem_wdata   (mem_wdata[g]),
      .mem_rdata   (mem_rdata[g])
    );
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if ((ibus_done[d] && dbus_done[d]) || ((ibus_done[d] || dbus_done[d]) && prev_done[d]))
        viol[d] <= viol[d] + 1;
      prev_done[d] <= ibus_done[d] || dbus_done[d];
    end
  end

  // One core transaction started in an IDLE cycle; inputs are scrambled after the sample.
  task automatic run_txn(input int d, input kind_e kind, input logic [14:0] addr,
                         input logic [47:0] wdata, input string tag);
    int   t, done_at, en_cnt, en_at, exp_done, exp_en;
    logic zero;
    zero     = (kind != K_FETCH) && (addr == 15'd0);
    exp_done = cyc + 2 + ((kind == K_WRITE) ? 0 : lat(d));
    exp_en   = zero ? 0 : 1;
    if (kind == K_FETCH) last_ibus[d] = model_word(d, addr);
    if (kind == K_READ)  last_dbus[d] = zero ? 48'd0 : model_word(d, addr);
    t = cyc;
    ibus_fetch[d]  = (kind == K_FETCH);
    dbus_read[d]   = (kind == K_READ);
    dbus_write[d]  = (kind == K_WRITE);
    ibus_addr[d]   = addr;
    dbus_addr[d]   = addr;
    dbus_output[d] = wdata;
    done_at = -1; en_cnt = 0; en_at = -1;
    for (int i = 0; i < 24 && done_at < 0; i++) begin
      @(negedge clk);
      ibus_addr[d]   = rand15();
      dbus_addr[d]   = rand15();
      dbus_output[d] = rand48();
      if (mem_en[d]) begin
        en_cnt++;
        en_at = cyc;
        checks++;
        if (mem_addr[d] !== addr || mem_we[d] !== (kind == K_WRITE) ||
            (kind == K_WRITE && mem_wdata[d] !== wdata))
          $display("FAIL %s d%0d mem_cmd: addr=%h we=%b wdata=%h, want addr=%h we=%b wdata=%h",
                   tag, d, mem_addr[d], mem_we[d], mem_wdata[d], addr, kind == K_WRITE, wdata);
        else passes++;
      end
      if (ibus_done[d] || dbus_done[d]) begin
        done_at = cyc;
        checks++;
        if (ibus_done[d] !== (kind == K_FETCH) || dbus_done[d] !== (kind != K_FETCH))
          $display("FAIL %s d%0d done_bus: ibus_done=%b dbus_done=%b", tag, d, ibus_done[d], dbus_done[d]);
        else passes++;
        checks++;
        if (ibus_input[d] !== last_ibus[d] || dbus_input[d] !== last_dbus[d])
          $display("FAIL %s d%0d data: ibus_input=%h dbus_input=%h, want %h %h",
                   tag, d, ibus_input[d], dbus_input[d], last_ibus[d], last_dbus[d]);
        else passes++;
      end
    end
    ibus_fetch[d] = 1'b0;
    dbus_read[d]  = 1'b0;
    dbus_write[d] = 1'b0;
    if (kind == K_WRITE && !zero) ref_mem[d * 32768 + int'(addr)] = wdata;
    checks++;
    if (done_at !== exp_done)
      $display("FAIL %s d%0d done_cycle: got %0d want %0d (-1 = timeout)", tag, d, done_at, exp_done);
    else passes++;
    checks++;
    if (en_cnt !== exp_en || (en_cnt == 1 && en_at !== t + 1))
      $display("FAIL %s d%0d mem_en: count=%0d at %0d, want count=%0d at %0d", tag, d, en_cnt, en_at, exp_en, t + 1);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (outs(d) !== '0) $display("FAIL reset_outputs d%0d: got %h want 0", d, outs(d));
      else passes++;
    end
  endtask

  task automatic test_fetch_basic();
    for (int d = 0; d < 2; d++) run_txn(d, K_FETCH, 15'o100, 48'd0, "fetch_0o100");
  endtask

  task automatic test_write_read();
    for (int d = 0; d < 2; d++) begin
      run_txn(d, K_WRITE, 15'd5, 48'hFFFF_0000_0001, "write_5");
      run_txn(d, K_READ,  15'd5, 48'd0,              "read_5");
    end
  endtask

  task automatic test_addr_zero();
    for (int d = 0; d < 2; d++) begin
      run_txn(d, K_WRITE, 15'd0, 48'h7, "write_0");
      run_txn(d, K_READ,  15'd0, 48'd0, "read_0");
      run_txn(d, K_FETCH, 15'd0, 48'd0, "fetch_0");
    end
  endtask

  task automatic test_arbitration();
    for (int d = 0; d < 2; d++) begin
      int t, dd, id, L;
      int en_cyc[$];
      logic [14:0] en_adr[$];
      logic [14:0] a_d, a_i;
      L   = lat(d);
      a_d = 15'($urandom_range(1, 32767));
      a_i = rand15();
      last_dbus[d] = model_word(d, a_d);
      last_ibus[d] = model_word(d, a_i);
      t = cyc;
      dbus_read[d] = 1'b1; dbus_addr[d] = a_d;
      ibus_fetch[d] = 1'b1; ibus_addr[d] = a_i;
      dd = -1; id = -1;
      for (int i = 0; i < 40 && id < 0; i++) begin
        @(negedge clk);
        if (mem_en[d]) begin en_cyc.push_back(cyc); en_adr.push_back(mem_addr[d]); end
        if (dbus_done[d]) begin
          dd = cyc;
          dbus_read[d] = 1'b0;
          checks++;
          if (dbus_input[d] !== last_dbus[d])
            $display("FAIL arb d%0d dbus_data: got %h want %h", d, dbus_input[d], last_dbus[d]);
          else passes++;
        end
        if (ibus_done[d]) begin
          id = cyc;
          checks++;
          if (ibus_input[d] !== last_ibus[d])
            $display("FAIL arb d%0d ibus_data: got %h want %h", d, ibus_input[d], last_ibus[d]);
          else passes++;
        end
      end
      ibus_fetch[d] = 1'b0;
      dbus_read[d]  = 1'b0;
      checks++;
      if (dd !== t + 2 + L || id !== t + 5 + 2 * L)
        $display("FAIL arb d%0d done_cycles: dbus=%0d ibus=%0d want %0d %0d", d, dd, id, t + 2 + L, t + 5 + 2 * L);
      else passes++;
      checks++;
      if (en_cyc.size() != 2)
        $display("FAIL arb d%0d mem_en_count: got %0d want 2", d, en_cyc.size());
      else if (en_cyc[0] != t + 1 || en_cyc[1] != t + 4 + L || en_adr[0] !== a_d || en_adr[1] !== a_i)
        $display("FAIL arb d%0d mem_en_order: cycles %0d,%0d addrs %h,%h want %0d,%0d %h,%h",
                 d, en_cyc[0], en_cyc[1], en_adr[0], en_adr[1], t + 1, t + 4 + L, a_d, a_i);
      else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_wait();
    int quiet;
    ibus_fetch[1] = 1'b1;
    ibus_addr[1]  = 15'o100;
    repeat (3) @(negedge clk);
    reset[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (outs(1) !== '0) $display("FAIL reset_mid_wait outputs: got %h want 0", outs(1));
    else passes++;
    ibus_fetch[1] = 1'b0;
    reset[1]      = 1'b0;
    last_ibus[1]  = '0;
    last_dbus[1]  = '0;
    quiet = 0;
    repeat (10) begin
      @(negedge clk);
      if (ibus_done[1] || dbus_done[1] || mem_en[1]) quiet++;
    end
    checks++;
    if (quiet != 0) $display("FAIL reset_mid_wait quiet: %0d active cycles, want 0", quiet);
    else passes++;
    run_txn(1, K_FETCH, 15'o100, 48'd0, "post_reset_fetch");
  endtask

  task automatic test_back_to_back();
    for (int d = 0; d < 2; d++) begin
      int t, k, en_cnt, L;
      logic [14:0] addrs [10];
      L = lat(d);
      foreach (addrs[j]) addrs[j] = rand15();
      t = cyc; k = 0; en_cnt = 0;
      ibus_fetch[d] = 1'b1;
      ibus_addr[d]  = addrs[0];
      for (int i = 0; i < 10 * (L + 3) + 10 && k < 10; i++) begin
        @(negedge clk);
        if (mem_en[d]) en_cnt++;
        if (ibus_done[d]) begin
          last_ibus[d] = model_word(d, addrs[k]);
          checks++;
          if (cyc != t + 2 + L + k * (L + 3) || ibus_input[d] !== last_ibus[d])
            $display("FAIL b2b d%0d uop%0d: cycle %0d data %h, want %0d %h",
                     d, k, cyc, ibus_input[d], t + 2 + L + k * (L + 3), last_ibus[d]);
          else passes++;
          k++;
          if (k < 10) ibus_addr[d] = addrs[k];
        end
      end
      ibus_fetch[d] = 1'b0;
      checks++;
      if (k != 10 || en_cnt != 10)
        $display("FAIL b2b d%0d counts: done=%0d mem_en=%0d want 10 10", d, k, en_cnt);
      else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 25; n++) begin
        kind_e       kind;
        logic [14:0] a;
        kind = kind_e'($urandom_range(0, 2));
        a    = ($urandom_range(0, 7) == 0) ? 15'd0 : 15'($urandom_range(1, 15));
        run_txn(d, kind, a, rand48(), "random");
      end
    end
  endtask

  task automatic test_protocol();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (viol[d] != 0) $display("FAIL protocol d%0d: %0d done overlap/repeat cycles, want 0", d, viol[d]);
      else passes++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset[d]       = 1'b1;
      ibus_fetch[d]  = 1'b0;
      ibus_addr[d]   = '0;
      dbus_read[d]   = 1'b0;
      dbus_write[d]  = 1'b0;
      dbus_addr[d]   = '0;
      dbus_output[d] = '0;
      last_ibus[d]   = '0;
      last_dbus[d]   = '0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clk);

    test_fetch_basic();
    test_write_read();
    test_addr_zero();
    test_arbitration();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    test_protocol();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
